switch_traversal: RTL

Registered switch-traversal stage directly downstream of the parallel port allocator. Each cycle it takes the five input-channel flits and their final port vectors (one-hot over five output links plus a BYPASS bit). It crosses productive flits onto registered output links and writes BYPASS flits into a multi-write side buffer. The side buffer drains through a valid/ready port back toward re-injection.

---
 rtl/switch_traversal_pkg.sv | 18 +
 rtl/switch_traversal_side_buffer.sv | 106 ++++++++++
 rtl/switch_traversal.sv | 111 +++++++++++
 3 files changed

// File: rtl/switch_traversal_pkg.sv
// Shared constants and helpers for the switch-traversal stage (replaces global.v).
package switch_traversal_pkg;

    localparam int NUM_CHANNEL_DEF = 5;
    localparam int NUM_PORT_DEF    = 6;
    localparam int FLIT_W_DEF      = 64;
    localparam int SIDE_DEPTH_DEF  = 8;
    localparam int BYPASS_BIT      = 5;
    localparam int DROP_W          = 8;

    function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] a,
                                                       input logic [DROP_W-1:0] b);
        logic [DROP_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DROP_W] ? '1 : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/switch_traversal_side_buffer.sv
// Multi-write (one port per channel), single-read FWFT side buffer for BYPASS flits
// with occupancy count, registered almost-full flag and saturating drop counter.
module side_buffer
    import switch_traversal_pkg::*;
#(
    parameter int NUM_CHANNEL = NUM_CHANNEL_DEF,
    parameter int FLIT_W      = FLIT_W_DEF,
    parameter int SIDE_DEPTH  = SIDE_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CHANNEL-1:0]        byp_valid_i,
    input  logic [NUM_CHANNEL*FLIT_W-1:0] byp_flit_i,
    input  logic                          rd_ready_i,
    output logic [FLIT_W-1:0]             rd_flit_o,
    output logic                          rd_valid_o,
    output logic                          almost_full_o,
    output logic [DROP_W-1:0]             drop_cnt_o
);

    localparam int AW = $clog2(SIDE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(SIDE_DEPTH);
    localparam logic [CW-1:0] AF_LIMIT = CW'(NUM_CHANNEL - 1);

    logic [FLIT_W-1:0]      mem_q [SIDE_DEPTH];
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   af_q, af_d;
    logic [DROP_W-1:0]      drop_q, drop_d;

    logic [CW-1:0]          free;
    logic [CW-1:0]          rank;
    logic [CW-1:0]          n_acc, n_drop;
    logic [NUM_CHANNEL-1:0] wr_en;
    logic [AW-1:0]          wr_addr [NUM_CHANNEL];
    logic                   deq;

    assign rd_valid_o    = (count_q != '0);
    assign rd_flit_o     = mem_q[rd_ptr_q];
    assign almost_full_o = af_q;
    assign drop_cnt_o    = drop_q;
    assign deq           = rd_valid_o && rd_ready_i;

    // Space is judged before this cycle's dequeue, so a full buffer drops even while draining.
    always_comb begin
        free   = DEPTH_C - count_q;
        rank   = '0;
        n_acc  = '0;
        n_drop = '0;
        wr_en  = '0;
        for (int unsigned i = 0; i < NUM_CHANNEL; i++) begin
            wr_addr[i] = '0;
            if (byp_valid_i[i]) begin
                if (rank < free) begin
                    wr_en[i]   = 1'b1;
                    wr_addr[i] = wr_ptr_q + rank[AW-1:0];
                    n_acc      = n_acc + CW'(1);
                end else begin
                    n_drop = n_drop + CW'(1);
                end
                rank = rank + CW'(1);
            end
        end
    end

    always_comb begin
        count_d  = count_q + n_acc - CW'(deq);
        wr_ptr_d = wr_ptr_q + n_acc[AW-1:0];
        rd_ptr_d = rd_ptr_q + AW'(deq);
        af_d     = (DEPTH_C - count_d) < AF_LIMIT;
        drop_d   = sat_add_drop(drop_q, DROP_W'(n_drop));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            af_q     <= 1'b0;
            drop_q   <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            af_q     <= af_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < SIDE_DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CHANNEL; i++) begin
                if (wr_en[i]) begin
                    mem_q[wr_addr[i]] <= byp_flit_i[i*FLIT_W +: FLIT_W];
                end
            end
        end
    end

endmodule

// File: rtl/switch_traversal.sv
// Registered switch-traversal stage: crossbar onto output links plus BYPASS side buffer.
// Optional port-vector checking is compiled in with `define SWITCH_CHECK_EN.
module switch_traversal
    import switch_traversal_pkg::*;
#(
    parameter int NUM_CHANNEL = NUM_CHANNEL_DEF,
    parameter int NUM_PORT    = NUM_PORT_DEF,
    parameter int FLIT_W      = FLIT_W_DEF,
    parameter int SIDE_DEPTH  = SIDE_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CHANNEL*FLIT_W-1:0]  flitIn,
    input  logic [NUM_CHANNEL*NUM_PORT-1:0] PVIn,
    output logic [(NUM_PORT-1)*FLIT_W-1:0] flitOut,
    output logic [NUM_PORT-2:0]            validOut,
    output logic [FLIT_W-1:0]              sideFlit,
    output logic                           sideValid,
    input  logic                           sideReady,
    output logic                           sideAlmostFull,
    output logic [DROP_W-1:0]              dropCnt,
    output logic                           errFlag
);

    localparam int NUM_LINK = NUM_PORT - 1;

    logic [NUM_PORT-1:0]        pv_row [NUM_CHANNEL];
    logic [NUM_CHANNEL-1:0]     byp_valid;
    logic [NUM_LINK-1:0]        link_valid_d, link_valid_q;
    logic [NUM_LINK*FLIT_W-1:0] link_flit_d, link_flit_q;

    for (genvar g = 0; g < NUM_CHANNEL; g++) begin : g_row
        assign pv_row[g]    = PVIn[g*NUM_PORT +: NUM_PORT];
        assign byp_valid[g] = pv_row[g][BYPASS_BIT];
    end

    // Ascending scan with a "taken" test gives the lowest-index channel priority per link.
    always_comb begin
        link_valid_d = '0;
        link_flit_d  = '0;
        for (int unsigned p = 0; p < NUM_LINK; p++) begin
            for (int unsigned i = 0; i < NUM_CHANNEL; i++) begin
                if (pv_row[i][p] && !link_valid_d[p]) begin
                    link_valid_d[p]                = 1'b1;
                    link_flit_d[p*FLIT_W +: FLIT_W] = flitIn[i*FLIT_W +: FLIT_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            link_valid_q <= '0;
            link_flit_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_flit_q  <= link_flit_d;
        end
    end

    assign validOut = link_valid_q;
    assign flitOut  = link_flit_q;

    side_buffer #(
        .NUM_CHANNEL (NUM_CHANNEL),
        .FLIT_W      (FLIT_W),
        .SIDE_DEPTH  (SIDE_DEPTH)
    ) u_side_buffer (
        .clk           (clk),
        .rst_n         (reset),
        .byp_valid_i   (byp_valid),
        .byp_flit_i    (flitIn),
        .rd_ready_i    (sideReady),
        .rd_flit_o     (sideFlit),
        .rd_valid_o    (sideValid),
        .almost_full_o (sideAlmostFull),
        .drop_cnt_o    (dropCnt)
    );

`ifdef SWITCH_CHECK_EN
    logic                err_q, err_d;
    logic [NUM_LINK-1:0] claimed;

    always_comb begin
        err_d   = err_q;
        claimed = '0;
        for (int unsigned i = 0; i < NUM_CHANNEL; i++) begin
            if ((pv_row[i] & (pv_row[i] - NUM_PORT'(1))) != '0) begin
                err_d = 1'b1;
            end
            if ((claimed & pv_row[i][NUM_LINK-1:0]) != '0) begin
                err_d = 1'b1;
            end
            claimed = claimed | pv_row[i][NUM_LINK-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign errFlag = err_q;
`else
    assign errFlag = 1'b0;
`endif

endmodule
